// File: rtl/seg_decode.sv
// seg_decode: debounced seven-segment pattern decoder feeding a small event FIFO.
//
// A pattern on seg_in must hold for STABLE_CYCLES consecutive samples before
// it is accepted. Each accepted non-blank pattern pushes one event
// {err, data[3:0]} into a DEPTH-entry FIFO. Recognised hex digits give
// err=0 with the digit value; any other non-blank pattern gives err=1, data=0.
// The blank pattern (all segments dark) is idle and never produces an event.
//
// Parameters:
//   STABLE_CYCLES  cycles a pattern must hold before acceptance (2..255)
//   DEPTH          FIFO entries (power of two, 2..16)
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   seg_in     active-low segment pattern, bit6=a ... bit0=g (0 = lit)
//   out_ready  consumer ready; a pop happens when out_valid && out_ready
//   out_valid  FIFO not empty
//   out_data   decoded digit at FIFO head (0 when FIFO empty)
//   out_err    FIFO head is an unrecognised pattern (0 when FIFO empty)
//   overflow   sticky: an event was dropped because the FIFO was full
//   level      current FIFO occupancy, 0..DEPTH

module seg_decode #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 seg_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [3:0]                 out_data,
  output logic                       out_err,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [6:0]    BLANK      = 7'b1111111;
  localparam logic [7:0]    CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0]    CNT_PUSH   = 8'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [6:0]    seg_q;
  logic [7:0]    cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    mem [DEPTH];

  logic [3:0] digit;
  logic       known;
  logic       is_blank;
  logic [4:0] entry;
  logic [4:0] head;
  logic       push;
  logic       pop;
  logic       full;
  logic       do_write;

  // Pattern-to-digit lookup; anything not listed is flagged as unknown.
  always_comb begin
    digit = 4'h0;
    known = 1'b1;
    case (seg_in)
      7'b0000001: digit = 4'h0;
      7'b1001111: digit = 4'h1;
      7'b0010010: digit = 4'h2;
      7'b0000110: digit = 4'h3;
      7'b1001100: digit = 4'h4;
      7'b0100100: digit = 4'h5;
      7'b0100000: digit = 4'h6;
      7'b0001111: digit = 4'h7;
      7'b0000000: digit = 4'h8;
      7'b0000100: digit = 4'h9;
      7'b0001000: digit = 4'hA;
      7'b1100000: digit = 4'hB;
      7'b0110001: digit = 4'hC;
      7'b1000010: digit = 4'hD;
      7'b0110000: digit = 4'hE;
      7'b0111000: digit = 4'hF;
      default:    known = 1'b0;
    endcase
  end

  assign is_blank = (seg_in == BLANK);
  assign entry    = known ? {1'b0, digit} : 5'b10000;

  // cnt only equals STABLE_CYCLES-1 once per episode on the way up to its
  // saturation value, so this fires exactly once per stable pattern.
  assign push     = (seg_in == seg_q) && (cnt == CNT_PUSH) && !is_blank;

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (level == LEVEL_FULL);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_write  = push && (!full || pop);

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[3:0] : 4'h0;
  assign out_err  = out_valid & head[4];

  // Storage array needs no reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Stability tracking, FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= BLANK;
      cnt      <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q) begin
        cnt <= 8'd1;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end

      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({do_write, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
